// File: rtl/cnn_axis_pkg.sv
// Shared constants and types for the AXI-Stream ifmap unpacker.
// Default geometry below; the top recomputes lane counts from its own parameters.
package cnn_axis_pkg;

    localparam int C_S_AXIS_TDATA_WIDTH_DEF = 32;
    localparam int ELEM_WIDTH_DEF           = 8;
    localparam int LANES                    = C_S_AXIS_TDATA_WIDTH_DEF / ELEM_WIDTH_DEF;

    // A single-lane word still needs a 1-bit index so ports never collapse to zero width.
    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANE_IDX_W = lane_idx_width(LANES);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/axis_ifmap_unpacker_lane_pick.sv
// Combinational lane priority encoder: next enabled lane above idx (or the lowest
// enabled lane when searching from the start), a found flag, and the highest enabled lane.
module lane_pick
    import cnn_axis_pkg::*;
#(
    parameter int N_LANES = LANES,
    parameter int IDX_W   = LANE_IDX_W
) (
    input  logic [N_LANES-1:0] mask_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               from_start_i,
    output logic [IDX_W-1:0]   next_o,
    output logic               found_o,
    output logic [IDX_W-1:0]   hi_o
);

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        hi_o    = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (mask_i[i]) begin
                hi_o = IDX_W'(i);
            end
        end
        // Descending scan so the lowest qualifying lane is the one left standing.
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
                next_o  = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_ifmap_unpacker.sv
// Serialises S_AXIS words into one element per cycle with last-marking and counting.
// Define UNPACK_STRB_EN to honour TSTRB (sparse lanes skipped, strb_err active).
module axis_ifmap_unpacker
    import cnn_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = C_S_AXIS_TDATA_WIDTH_DEF,
    parameter int ELEM_WIDTH           = ELEM_WIDTH_DEF,
    parameter int COUNT_WIDTH          = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              axis_en,
    input  logic                              axis_clear,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic [ELEM_WIDTH-1:0]             elem_data,
    output logic                              elem_valid,
    output logic                              elem_last,
    input  logic                              elem_ready,
    output logic [COUNT_WIDTH-1:0]            elem_count,
    output logic                              strb_err
);

    localparam int N_LANES    = C_S_AXIS_TDATA_WIDTH / ELEM_WIDTH;
    localparam int IDX_W      = lane_idx_width(N_LANES);
    localparam int LANE_BYTES = ELEM_WIDTH / 8;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] data_q, data_d;
    logic [N_LANES-1:0]              mask_q, mask_d;
    logic                            last_q, last_d;
    logic [ELEM_WIDTH-1:0]           elem_data_q, elem_data_d;
    logic                            elem_last_q, elem_last_d;
    logic [COUNT_WIDTH-1:0]          count_q, count_d;
    logic                            strb_err_q, strb_err_d;

    logic [N_LANES-1:0] in_mask;
    logic [IDX_W-1:0]   held_next, held_hi, in_first, in_hi;
    logic               held_found, in_found;
    logic               tready, accept, hs;

`ifdef UNPACK_STRB_EN
    // A lane is enabled only when every byte strobe covering it is set.
    always_comb begin
        in_mask = '0;
        for (int i = 0; i < N_LANES; i++) begin
            in_mask[i] = &S_AXIS_TSTRB[i*LANE_BYTES +: LANE_BYTES];
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^S_AXIS_TSTRB;
    assign in_mask     = '1;
`endif

    lane_pick #(.N_LANES(N_LANES), .IDX_W(IDX_W)) u_pick_held (
        .mask_i       (mask_q),
        .idx_i        (idx_q),
        .from_start_i (1'b0),
        .next_o       (held_next),
        .found_o      (held_found),
        .hi_o         (held_hi)
    );

    lane_pick #(.N_LANES(N_LANES), .IDX_W(IDX_W)) u_pick_in (
        .mask_i       (in_mask),
        .idx_i        ('0),
        .from_start_i (1'b1),
        .next_o       (in_first),
        .found_o      (in_found),
        .hi_o         (in_hi)
    );

    function automatic logic [ELEM_WIDTH-1:0] lane_of(input logic [C_S_AXIS_TDATA_WIDTH-1:0] w,
                                                      input logic [IDX_W-1:0] i);
        return w[int'(i)*ELEM_WIDTH +: ELEM_WIDTH];
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        mask_d      = mask_q;
        last_d      = last_q;
        elem_data_d = elem_data_q;
        elem_last_d = elem_last_q;
        count_d     = count_q;
        strb_err_d  = 1'b0;
        tready      = 1'b0;
        accept      = 1'b0;
        hs          = (state_q == HOLD) && elem_ready;

        if (axis_clear) begin
            state_d     = EMPTY;
            idx_d       = '0;
            count_d     = '0;
            elem_last_d = 1'b0;
        end else begin
            // A new word may only enter when nothing is held or the last lane is leaving now.
            if (state_q == EMPTY) begin
                tready = axis_en && !rst;
            end else begin
                tready = axis_en && elem_ready && !held_found;
            end
            accept = tready && S_AXIS_TVALID;

            if (hs) begin
                count_d = elem_last_q ? '0 : count_q + COUNT_WIDTH'(1);
            end

            if (hs && held_found) begin
                idx_d       = held_next;
                elem_data_d = lane_of(data_q, held_next);
                elem_last_d = last_q && (held_next == held_hi);
            end else if ((state_q == EMPTY) || hs) begin
                if (accept && in_found) begin
                    state_d     = HOLD;
                    data_d      = S_AXIS_TDATA;
                    mask_d      = in_mask;
                    last_d      = S_AXIS_TLAST;
                    idx_d       = in_first;
                    elem_data_d = lane_of(S_AXIS_TDATA, in_first);
                    elem_last_d = S_AXIS_TLAST && (in_first == in_hi);
                end else begin
                    state_d     = EMPTY;
                    elem_last_d = 1'b0;
                    if (accept && S_AXIS_TLAST) begin
                        count_d = '0;
`ifdef UNPACK_STRB_EN
                        strb_err_d = 1'b1;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            last_q      <= 1'b0;
            elem_data_q <= '0;
            elem_last_q <= 1'b0;
            count_q     <= '0;
            strb_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            elem_data_q <= elem_data_d;
            elem_last_q <= elem_last_d;
            count_q     <= count_d;
            strb_err_q  <= strb_err_d;
        end
    end

    assign S_AXIS_TREADY = tready;
    assign elem_valid    = (state_q == HOLD);
    assign elem_data     = elem_data_q;
    assign elem_last     = elem_last_q;
    assign elem_count    = count_q;
    assign strb_err      = strb_err_q;

endmodule

// File: tb/tb_axis_ifmap_unpacker.sv
// Scoreboard bench for axis_ifmap_unpacker: expected elements queued on word accept,
// popped and compared on each element handshake.
module tb_axis_ifmap_unpacker;

`ifdef UNPACK_STRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        axis_en;
    logic        axis_clear;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TSTRB;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TVALID;
    logic [7:0]  elem_data;
    logic        elem_valid;
    logic        elem_last;
    logic        elem_ready;
    logic [15:0] elem_count;
    logic        strb_err;

    axis_ifmap_unpacker dut (
        .clk           (clk),
        .rst           (rst),
        .axis_en       (axis_en),
        .axis_clear    (axis_clear),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .elem_data     (elem_data),
        .elem_valid    (elem_valid),
        .elem_last     (elem_last),
        .elem_ready    (elem_ready),
        .elem_count    (elem_count),
        .strb_err      (strb_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state: entry = {last_lane_of_word, elem_last, data}
    logic [9:0]  exp_q[$];
    int          hs_log[$];
    logic [15:0] exp_cnt = '0;
    int          exp_strb = 0;
    int          strb_seen = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        stalled_prev = 1'b0;
    logic [7:0]  held_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model of one word: returns 1 for a zero-lane word (nothing emitted).
    function automatic bit push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        logic [3:0] m;
        int hi;
        m  = STRB_EN ? s : 4'hF;
        hi = -1;
        for (int i = 0; i < 4; i++) if (m[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) exp_q.push_back({(i == hi), (l && (i == hi)), d[i*8 +: 8]});
        end
        return (m == 4'h0);
    endfunction

    // driver tasks (called at posedge+1, return at posedge+1)
    task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l, input bit rnd);
        bit accepted;
        bit zero;
        accepted      = 1'b0;
        S_AXIS_TDATA  = d;
        S_AXIS_TSTRB  = s;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (rnd) begin
                elem_ready = 1'($urandom_range(0, 1));
                axis_en    = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (S_AXIS_TREADY) begin
                zero = push_word(d, s, l);
                @(posedge clk); #1;
                if (zero && l) begin
                    exp_cnt = '0;
                    if (STRB_EN) exp_strb++;
                end
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic idle_bus();
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            if (rnd) elem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        elem_ready = 1'b1;
        axis_en    = 1'b1;
    endtask

    task automatic wait_hs(input int n);
        for (int k = 0; k < 50; k++) begin
            if (hs_log.size() >= n) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, 32'(S_AXIS_TREADY), 32'd0);
        check({tag, "_valid"},  32'(elem_valid),    32'd0);
        check({tag, "_last"},   32'(elem_last),     32'd0);
        check({tag, "_data"},   32'(elem_data),     32'd0);
        check({tag, "_count"},  32'(elem_count),    32'd0);
        check({tag, "_strberr"}, 32'(strb_err),     32'd0);
    endtask

    // monitor: handshake scoring, TREADY rule, stall stability
    always @(negedge clk) begin
        logic [9:0] e;
        logic       exp_tr;
        cyc++;
        if (strb_err) strb_seen++;
        if (!rst) begin
            if (elem_valid && exp_q.size() == 0) begin
                check("spurious_elem", 32'(elem_valid), 32'd0);
            end else begin
                if (axis_clear)      exp_tr = 1'b0;
                else if (elem_valid) exp_tr = axis_en && elem_ready && exp_q[0][9];
                else                 exp_tr = axis_en;
                check("tready", 32'(S_AXIS_TREADY), 32'(exp_tr));
            end
            if (stalled_prev) begin
                check("stall_valid", 32'(elem_valid), 32'd1);
                check("stall_data",  32'(elem_data),  32'(held_data));
            end
            if (elem_valid && elem_ready && !axis_clear && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("elem_data",  32'(elem_data),  32'(e[7:0]));
                check("elem_last",  32'(elem_last),  32'(e[8]));
                check("elem_count", 32'(elem_count), 32'(exp_cnt));
                exp_cnt = e[8] ? 16'd0 : exp_cnt + 16'd1;
                hs_log.push_back(cyc);
            end
            stalled_prev = elem_valid && !elem_ready && !axis_clear;
            held_data    = elem_data;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        bit pat[4];
        int s0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; axis_en = 1'b0; axis_clear = 1'b0; elem_ready = 1'b1;
        S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TLAST = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0; axis_en = 1'b1;
        @(posedge clk); #1;

        // single full word, latency and last marking
        hs_log.delete();
        send_word(32'h44332211, 4'hF, 1'b1, 1'b0);
        idle_bus();
        @(negedge clk);
        check("lat_valid", 32'(elem_valid), 32'd1);
        check("lat_data",  32'(elem_data),  32'h11);
        @(posedge clk); #1;
        drain(1'b0);
        check("t1_count", 32'(elem_count), 32'd0);
        check("t1_valid_off", 32'(elem_valid), 32'd0);
        check("t1_n", 32'(hs_log.size()), 32'd4);
        if (hs_log.size() == 4) check("t1_span", 32'(hs_log[3] - hs_log[0]), 32'd3);

        // three back-to-back words, no bubble
        hs_log.delete();
        send_word(32'h03020100, 4'hF, 1'b0, 1'b0);
        send_word(32'h07060504, 4'hF, 1'b0, 1'b0);
        send_word(32'h0B0A0908, 4'hF, 1'b1, 1'b0);
        idle_bus();
        drain(1'b0);
        check("t2_n", 32'(hs_log.size()), 32'd12);
        if (hs_log.size() == 12) check("t2_span", 32'(hs_log[11] - hs_log[0]), 32'd11);
        check("t2_count", 32'(elem_count), 32'd0);

        // sparse strobes
        hs_log.delete();
        send_word(32'hDDCCBBAA, 4'hA, 1'b1, 1'b0);
        idle_bus();
        drain(1'b0);
        check("t3_n", 32'(hs_log.size()), STRB_EN ? 32'd2 : 32'd4);
        check("t3_count", 32'(elem_count), 32'd0);

        // downstream stall mid-word
        hs_log.delete();
        send_word(32'h88776655, 4'hF, 1'b1, 1'b0);
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            elem_ready = pat[i];
            @(posedge clk); #1;
        end
        elem_ready = 1'b1;
        drain(1'b0);
        check("t4_n", 32'(hs_log.size()), 32'd4);
        check("t4_count", 32'(elem_count), 32'd0);

        // zero-strobe TLAST word after a partial packet
        hs_log.delete();
        s0 = strb_seen;
        send_word(32'h12345678, 4'hF, 1'b0, 1'b0);
        send_word(32'hCAFEF00D, 4'h0, 1'b1, 1'b0);
        idle_bus();
        drain(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_strb_err", 32'(strb_seen - s0), STRB_EN ? 32'd1 : 32'd0);
        check("t5_count", 32'(elem_count), 32'd0);
        check("t5_n", 32'(hs_log.size()), STRB_EN ? 32'd4 : 32'd8);

        // clear after the second element
        hs_log.delete();
        send_word(32'h0D0C0B0A, 4'hF, 1'b1, 1'b0);
        idle_bus();
        wait_hs(2);
        axis_clear = 1'b1; elem_ready = 1'b0;
        @(posedge clk); #1;
        axis_clear = 1'b0; elem_ready = 1'b1;
        exp_q.delete(); exp_cnt = '0;
        @(negedge clk);
        check("t6_valid", 32'(elem_valid), 32'd0);
        check("t6_count", 32'(elem_count), 32'd0);
        check("t6_n", 32'(hs_log.size()), 32'd2);
        @(posedge clk); #1;

        // reset mid-word
        hs_log.delete();
        send_word(32'h04030201, 4'hF, 1'b1, 1'b0);
        idle_bus();
        wait_hs(1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); exp_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(elem_valid), 32'd0);
        end
        @(posedge clk); #1;

        // randomised words, strobes, enable and backpressure
        for (int i = 0; i < 12; i++) begin
            send_word($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b1);
        end
        idle_bus();
        drain(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rand_count", 32'(elem_count), 32'(exp_cnt));
        check("strb_err_total", 32'(strb_seen), 32'(exp_strb));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
